// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: bus command encodings, tag/counter widths, owner encoding and saturating counter helper
package mem_arbiter_pkg;
   localparam int TAG_W = 4;
   localparam int CNT_W = 5;
   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;
   localparam logic OWNER_ICACHE = 1'b0;
   localparam logic OWNER_DCACHE = 1'b1;
   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t CNT_MAX = 5'd16;
   // Simultaneous increment and decrement cancel; the count stays within 0..CNT_MAX.
   function automatic cnt_t sat_step(input cnt_t c, input logic inc, input logic dec);
      return (inc && !dec && c != CNT_MAX) ? c + 5'd1 : (dec && !inc && c != '0) ? c - 5'd1 : c;
   endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals of mem_arbiter
//   slave  : arbiter side (takes Icache/Dcache requests and memory replies, drives grant, routing, status)
//   master : environment side (drives requests and memory replies)
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;
   logic [1:0] Icache2mem_command;
   logic [63:0] Icache2mem_addr;
   logic [1:0] Dcache2mem_command;
   logic [63:0] Dcache2mem_addr;
   logic [63:0] Dcache2mem_data;
   tag_t mem2proc_response;
   logic [63:0] mem2proc_data;
   tag_t mem2proc_tag;
   logic [1:0] proc2mem_command;
   logic [63:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   tag_t Imem2proc_response;
   tag_t Dmem2proc_response;
   tag_t Imem2proc_tag;
   tag_t Dmem2proc_tag;
   logic [63:0] mem2proc_data_out;
   cnt_t icache_outstanding;
   cnt_t dcache_outstanding;
   logic stray_tag;
   modport slave (
      input Icache2mem_command, Icache2mem_addr, Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
      input mem2proc_response, mem2proc_data, mem2proc_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data, Imem2proc_response, Dmem2proc_response,
      output Imem2proc_tag, Dmem2proc_tag, mem2proc_data_out, icache_outstanding, dcache_outstanding, stray_tag
   );
   modport master (
      output Icache2mem_command, Icache2mem_addr, Dcache2mem_command, Dcache2mem_addr, Dcache2mem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input proc2mem_command, proc2mem_addr, proc2mem_data, Imem2proc_response, Dmem2proc_response,
      input Imem2proc_tag, Dmem2proc_tag, mem2proc_data_out, icache_outstanding, dcache_outstanding, stray_tag
   );
endinterface

// File: rtl/mem_tag_table.sv
// mem_tag_table: per-tag valid/owner table with allocate, retire and combinational lookup
//   clock, reset (sync, active-low) ; alloc_en/alloc_tag/alloc_owner ; retire_en/retire_tag ;
//   lookup_tag -> lookup_valid, lookup_owner
module mem_tag_table
   import mem_arbiter_pkg::*;
#(
   parameter int NUM_TAGS = 16
) (
   input logic clock,
   input logic reset,
   input logic alloc_en,
   input tag_t alloc_tag,
   input logic alloc_owner,
   input logic retire_en,
   input tag_t retire_tag,
   input tag_t lookup_tag,
   output logic lookup_valid,
   output logic lookup_owner
);
   logic [NUM_TAGS-1:0] valid;
   logic [NUM_TAGS-1:0] owner;
   // Allocation is written after retirement so a tag retired and re-issued in one cycle stays valid.
   always_ff @(posedge clock)
      if (!reset) begin
         valid <= '0;
         owner <= '0;
      end else begin
         if (retire_en && retire_tag != '0) valid[retire_tag] <= 1'b0;
         if (alloc_en && alloc_tag != '0) begin
            valid[alloc_tag] <= 1'b1;
            owner[alloc_tag] <= alloc_owner;
         end
      end
   always_comb begin
      lookup_valid = lookup_tag != '0 && valid[lookup_tag];
      lookup_owner = owner[lookup_tag];
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: Icache/Dcache arbiter for one memory port with tag ownership tracking and return routing
//   clock, reset (sync, active-low) ; bus : mem_arbiter_if.slave (requests, memory replies, grant, routed tags, status)
//   Optional macro MEM_ARB_STARVE_GUARD_EN: Icache wins a contested cycle after STARVE_LIMIT consecutive losses;
//   without it Dcache has strict priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int NUM_TAGS = 16
) (
   input logic clock,
   input logic reset,
   mem_arbiter_if.slave bus
);
   logic i_req, d_req, grant_i, starve_hit, load_ok, ret_valid, ret_owner, hit;
   logic [1:0] cmd;
   always_comb begin
      i_req = bus.Icache2mem_command != BUS_NONE;
      d_req = bus.Dcache2mem_command != BUS_NONE;
      grant_i = i_req && (!d_req || starve_hit);
      cmd = !reset ? BUS_NONE : grant_i ? bus.Icache2mem_command : bus.Dcache2mem_command;
      load_ok = cmd == BUS_LOAD && bus.mem2proc_response != '0;
      hit = reset && ret_valid;
      bus.proc2mem_command = cmd;
      bus.proc2mem_addr = grant_i ? bus.Icache2mem_addr : bus.Dcache2mem_addr;
      bus.proc2mem_data = grant_i ? '0 : bus.Dcache2mem_data;
      bus.Imem2proc_response = (reset && grant_i) ? bus.mem2proc_response : '0;
      bus.Dmem2proc_response = (reset && d_req && !grant_i) ? bus.mem2proc_response : '0;
      bus.Imem2proc_tag = (hit && ret_owner == OWNER_ICACHE) ? bus.mem2proc_tag : '0;
      bus.Dmem2proc_tag = (hit && ret_owner == OWNER_DCACHE) ? bus.mem2proc_tag : '0;
      bus.mem2proc_data_out = bus.mem2proc_data;
   end
   mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_table (
      .clock(clock),
      .reset(reset),
      .alloc_en(load_ok),
      .alloc_tag(bus.mem2proc_response),
      .alloc_owner(grant_i ? OWNER_ICACHE : OWNER_DCACHE),
      .retire_en(hit),
      .retire_tag(bus.mem2proc_tag),
      .lookup_tag(bus.mem2proc_tag),
      .lookup_valid(ret_valid),
      .lookup_owner(ret_owner)
   );
   always_ff @(posedge clock)
      if (!reset) begin
         bus.icache_outstanding <= '0;
         bus.dcache_outstanding <= '0;
         bus.stray_tag <= 1'b0;
      end else begin
         bus.icache_outstanding <= sat_step(bus.icache_outstanding, load_ok && grant_i, hit && ret_owner == OWNER_ICACHE);
         bus.dcache_outstanding <= sat_step(bus.dcache_outstanding, load_ok && !grant_i, hit && ret_owner == OWNER_DCACHE);
         bus.stray_tag <= bus.mem2proc_tag != '0 && !ret_valid;
      end
`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [2:0] starve_cnt;
   always_comb starve_hit = starve_cnt == 3'(STARVE_LIMIT);
   // A forced but rejected Icache grant holds the count, so Icache keeps priority until accepted.
   always_ff @(posedge clock)
      if (!reset || !i_req || (grant_i && bus.mem2proc_response != '0)) starve_cnt <= '0;
      else if (!grant_i && starve_cnt != 3'd7) starve_cnt <= starve_cnt + 3'd1;
`else
   logic unused_limit;
   always_comb begin
      starve_hit = 1'b0;
      unused_limit = STARVE_LIMIT != 0;
   end
`endif
endmodule
